// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared widths, reset seed, FSM states and feedback function for the LFSR arbiter
package lfsr_pkg;

  localparam int WIDTH = 6;
  localparam logic [WIDTH-1:0] SEED_DEFAULT = 6'b111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEED    = 2'd1,
    STEP    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  // One advance: q0<=q5, q1<=q0, q2<=q1, q3<=q2^q5, q4<=q3, q5<=q4
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {v[4], v[3], v[2] ^ v[5], v[1], v[0], v[5]};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - 6-bit feedback shift register with load (priority) and advance enable
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED_DEFAULT;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/lfsr_arb_ctrl.sv
// rtl/lfsr_arb_ctrl.sv - round-robin sequencer sharing one LFSR between two requesters
module lfsr_arb_ctrl
  import lfsr_pkg::*;
#(
  parameter int STEPS = 6,
  parameter int NREQ  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_seed_valid,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_data,
  output logic             busy
);

  localparam logic [5:0] STEPS_W = 6'(STEPS);

  state_t           state, state_nxt;
  logic [5:0]       cnt;
  logic             rr_ptr;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] load_val;
  logic             lfsr_load;
  logic             lfsr_en;
  logic [NREQ-1:0]  gnt_sel;

  // A zero seed would lock the register up, so it is replaced by the default.
  assign load_val = (seed_q == '0) ? SEED_DEFAULT : seed_q;
  assign busy     = (state != IDLE);

  lfsr_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (load_val),
    .en       (lfsr_en),
    .q        (lfsr_q)
  );

  always_comb begin
    gnt_sel = '0;
    if (req == 2'b11) begin
      gnt_sel = rr_ptr ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      gnt_sel = 2'b01;
    end else if (req[1]) begin
      gnt_sel = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_seed_valid) begin
          state_nxt = SEED;
        end else if (req != '0) begin
          state_nxt = STEP;
        end
      end
      SEED: begin
        lfsr_load = 1'b1;
        state_nxt = IDLE;
      end
      STEP: begin
        lfsr_en = 1'b1;
        if (cnt == 6'd1) begin
          state_nxt = DELIVER;
        end
      end
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The word is registered on the last advance so it lines up with DELIVER.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      cnt       <= '0;
      rr_ptr    <= 1'b1;
      seed_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_seed_valid) begin
            seed_q <= cfg_seed;
          end else if (req != '0) begin
            gnt <= gnt_sel;
            cnt <= STEPS_W;
          end
        end
        STEP: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            rnd_valid <= 1'b1;
            rnd_data  <= lfsr_step(lfsr_q);
          end
        end
        DELIVER: begin
          gnt       <= '0;
          rnd_valid <= 1'b0;
          rr_ptr    <= gnt[1];
        end
        default: ;
      endcase
    end
  end

endmodule
